// File: rtl/reg_disp_pkg.sv
// Shared types and sizing helpers for the register-display sequencer.
package reg_disp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        AGAP,
        SETUP,
        STROBE,
        HOLD
    } state_e;

    // Number of BUS_W-bit beats needed to carry a REG_W-bit register.
    function automatic int unsigned beats(input int unsigned reg_w, input int unsigned bus_w);
        return (reg_w + bus_w - 1) / bus_w;
    endfunction

    // Width of a counter running 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/reg_disp_serializer.sv
// Snapshot shift register: holds the MSB-padded register and presents the top BUS_W-bit slice.
module reg_disp_serializer
    import reg_disp_pkg::*;
#(
    parameter int unsigned REG_W = 16,
    parameter int unsigned BUS_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [REG_W-1:0] din,
    output logic [BUS_W-1:0] slice
);

    localparam int unsigned PAD_W = beats(REG_W, BUS_W) * BUS_W;

    logic [PAD_W-1:0] sh_d, sh_q;

    always_comb begin
        sh_d = sh_q;
        if (load) begin
            sh_d = PAD_W'(din);
        end else if (shift) begin
            sh_d = sh_q << BUS_W;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_q <= '0;
        end else begin
            sh_q <= sh_d;
        end
    end

    assign slice = sh_q[PAD_W-1 -: BUS_W];

endmodule

// File: rtl/reg_disp_seq.sv
// Register-display sequencer: address phase on ALE, then MSB-first data beats on En.
// Optional auto-scan of the register bank when REG_DISP_SCAN_EN is defined.
module reg_disp_seq
    import reg_disp_pkg::*;
#(
    parameter int unsigned NREG       = 4,
    parameter int unsigned REG_W      = 16,
    parameter int unsigned BUS_W      = 5,
    parameter int unsigned STROBE_CYC = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      pause,
    input  logic [$clog2(NREG)-1:0]   regSelect,
    input  logic [NREG*REG_W-1:0]     regFile,
`ifdef REG_DISP_SCAN_EN
    input  logic                      scanMode,
`endif
    output logic                      ALE,
    output logic                      En,
    output logic                      Rw,
    output logic [BUS_W-1:0]          dispReg,
    output logic                      busy,
    output logic                      frameDone
);

    localparam int unsigned IDX_W = $clog2(NREG);
    localparam int unsigned NBEAT = beats(REG_W, BUS_W);
    localparam int unsigned SC_W  = cnt_w(STROBE_CYC);
    localparam int unsigned BC_W  = cnt_w(NBEAT);
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(STROBE_CYC - 1);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(NBEAT - 1);

    state_e           state_d, state_q;
    logic [SC_W-1:0]  sc_d, sc_q;
    logic [BC_W-1:0]  bc_d, bc_q;
    logic             ale_d, ale_q, en_d, en_q, rw_d, rw_q;
    logic             busy_d, busy_q, fd_d, fd_q;
    logic [BUS_W-1:0] disp_d, disp_q;

    logic             ser_load, ser_shift;
    logic [BUS_W-1:0] ser_slice;
    logic [IDX_W-1:0] sel_idx;
    logic [REG_W-1:0] sel_data;

`ifdef REG_DISP_SCAN_EN
    logic [IDX_W-1:0] scan_d, scan_q;
    logic             scan_frame_d, scan_frame_q;
    assign sel_idx = scanMode ? scan_q : regSelect;
`else
    assign sel_idx = regSelect;
`endif

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NREG; i++) begin
            if (IDX_W'(i) == sel_idx) sel_data = regFile[i*REG_W +: REG_W];
        end
    end

    reg_disp_serializer #(.REG_W(REG_W), .BUS_W(BUS_W)) u_ser (
        .clk   (clk),
        .rst   (rst),
        .load  (ser_load),
        .shift (ser_shift),
        .din   (sel_data),
        .slice (ser_slice)
    );

    // Next state and next registered outputs; pause holds everything but frameDone.
    always_comb begin
        state_d   = state_q;
        sc_d      = sc_q;
        bc_d      = bc_q;
        ale_d     = ale_q;
        en_d      = en_q;
        rw_d      = rw_q;
        busy_d    = busy_q;
        disp_d    = disp_q;
        fd_d      = 1'b0;
        ser_load  = 1'b0;
        ser_shift = 1'b0;
`ifdef REG_DISP_SCAN_EN
        scan_d       = scan_q;
        scan_frame_d = scan_frame_q;
`endif
        if (!pause) begin
            unique case (state_q)
                IDLE: begin
                    state_d  = ADDR;
                    sc_d     = '0;
                    bc_d     = '0;
                    ale_d    = 1'b1;
                    rw_d     = 1'b0;
                    busy_d   = 1'b1;
                    disp_d   = BUS_W'(sel_idx);
                    ser_load = 1'b1;
`ifdef REG_DISP_SCAN_EN
                    scan_frame_d = scanMode;
`endif
                end
                ADDR: begin
                    if (sc_q == SC_LAST) begin
                        state_d = AGAP;
                        ale_d   = 1'b0;
                    end else begin
                        sc_d = sc_q + SC_W'(1);
                    end
                end
                AGAP: begin
                    state_d   = SETUP;
                    disp_d    = ser_slice;
                    ser_shift = 1'b1;
                end
                SETUP: begin
                    state_d = STROBE;
                    sc_d    = '0;
                    en_d    = 1'b1;
                end
                STROBE: begin
                    if (sc_q == SC_LAST) begin
                        state_d = HOLD;
                        en_d    = 1'b0;
                    end else begin
                        sc_d = sc_q + SC_W'(1);
                    end
                end
                HOLD: begin
                    if (bc_q == BC_LAST) begin
                        state_d = IDLE;
                        rw_d    = 1'b1;
                        busy_d  = 1'b0;
                        disp_d  = '0;
                        fd_d    = 1'b1;
`ifdef REG_DISP_SCAN_EN
                        if (scan_frame_q) begin
                            scan_d = (scan_q == IDX_W'(NREG - 1)) ? '0 : scan_q + IDX_W'(1);
                        end
`endif
                    end else begin
                        state_d   = SETUP;
                        bc_d      = bc_q + BC_W'(1);
                        disp_d    = ser_slice;
                        ser_shift = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sc_q    <= '0;
            bc_q    <= '0;
            ale_q   <= 1'b0;
            en_q    <= 1'b0;
            rw_q    <= 1'b1;
            busy_q  <= 1'b0;
            disp_q  <= '0;
            fd_q    <= 1'b0;
`ifdef REG_DISP_SCAN_EN
            scan_q       <= '0;
            scan_frame_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sc_q    <= sc_d;
            bc_q    <= bc_d;
            ale_q   <= ale_d;
            en_q    <= en_d;
            rw_q    <= rw_d;
            busy_q  <= busy_d;
            disp_q  <= disp_d;
            fd_q    <= fd_d;
`ifdef REG_DISP_SCAN_EN
            scan_q       <= scan_d;
            scan_frame_q <= scan_frame_d;
`endif
        end
    end

    assign ALE       = ale_q;
    assign En        = en_q;
    assign Rw        = rw_q;
    assign busy      = busy_q;
    assign dispReg   = disp_q;
    assign frameDone = fd_q;

endmodule

// File: tb/tb_reg_disp_seq.sv
// Scoreboard bench for reg_disp_seq: expected strobe windows queued at stimulus, popped per frame.
module tb_reg_disp_seq;

    localparam int unsigned NREG       = 4;
    localparam int unsigned REG_W      = 16;
    localparam int unsigned BUS_W      = 5;
    localparam int unsigned STROBE_CYC = 2;
    localparam int unsigned BEATS      = 4;
    localparam int unsigned FRAME_LEN  = STROBE_CYC + 1 + BEATS * (STROBE_CYC + 2);

    typedef struct {
        bit               kind;   // 0 = ALE window, 1 = En window
        logic [BUS_W-1:0] val;
        int               len;
    } obs_t;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  pause;
    logic [1:0]            regSelect;
    logic [NREG*REG_W-1:0] regFile;
`ifdef REG_DISP_SCAN_EN
    logic                  scanMode;
`endif
    logic                  ALE, En, Rw, busy, frameDone;
    logic [BUS_W-1:0]      dispReg;

    obs_t exp_q[$];
    obs_t obs_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   col_fd, col_ale0, col_unstable, col_busbad;

    always #5 clk = ~clk;

    reg_disp_seq #(
        .NREG(NREG), .REG_W(REG_W), .BUS_W(BUS_W), .STROBE_CYC(STROBE_CYC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pause     (pause),
        .regSelect (regSelect),
        .regFile   (regFile),
`ifdef REG_DISP_SCAN_EN
        .scanMode  (scanMode),
`endif
        .ALE       (ALE),
        .En        (En),
        .Rw        (Rw),
        .dispReg   (dispReg),
        .busy      (busy),
        .frameDone (frameDone)
    );

    function automatic logic [REG_W-1:0] reg_of(input int i);
        return regFile[i*REG_W +: REG_W];
    endfunction

    // Expected frame: address window, then MSB-first slices of the zero-padded value.
    task automatic push_frame(input int idx, input logic [REG_W-1:0] val);
        logic [BEATS*BUS_W-1:0] p;
        p = {{(BEATS*BUS_W-REG_W){1'b0}}, val};
        exp_q.push_back('{1'b0, BUS_W'(idx), int'(STROBE_CYC)});
        for (int b = 0; b < BEATS; b++)
            exp_q.push_back('{1'b1, p[BEATS*BUS_W-1-BUS_W*b -: BUS_W], int'(STROBE_CYC)});
    endtask

    // Records strobe windows until frameDone; returns at the negedge where frameDone is seen.
    task automatic collect_frame(input int max_cyc);
        logic             prev_ale, prev_en;
        logic [BUS_W-1:0] cur;
        int               len;
        obs_q.delete();
        col_fd = -1; col_ale0 = -1; col_unstable = 0; col_busbad = 0;
        prev_ale = 1'b0; prev_en = 1'b0; cur = '0; len = 0;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk);
            if ((ALE && !prev_ale) || (En && !prev_en)) begin
                cur = dispReg;
                len = 0;
                if (ALE && col_ale0 < 0) col_ale0 = c;
            end
            if (ALE || En) begin
                len++;
                if (dispReg !== cur) col_unstable++;
            end
            if (prev_ale && !ALE) obs_q.push_back('{1'b0, cur, len});
            if (prev_en && !En)   obs_q.push_back('{1'b1, cur, len});
            if (col_ale0 >= 0 && !frameDone && (busy !== 1'b1 || Rw !== 1'b0)) col_busbad++;
            if (frameDone === 1'b1 && col_ale0 >= 0) begin
                col_fd = c - col_ale0;
                break;
            end
            prev_ale = ALE;
            prev_en  = En;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; pause = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tests_run++;
            if ({ALE, En, Rw, busy, frameDone} !== 5'b00100 || dispReg !== '0) begin
                tests_failed++;
                $display("FAIL reset_idle cyc%0d: ALE,En,Rw,busy,frameDone=%b dispReg=%h, required 00100 / 00",
                         c, {ALE, En, Rw, busy, frameDone}, dispReg);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_single_frame();
        obs_t e, o;
        regSelect = 2'd2;
        push_frame(2, 16'hA5C3);
        pause = 1'b0;
        collect_frame(60);
        pause = 1'b1;
        tests_run++;
        if (col_fd != int'(FRAME_LEN)) begin
            tests_failed++;
            $display("FAIL single_frame length: got %0d, required %0d", col_fd, FRAME_LEN);
        end
        tests_run++;
        if (col_unstable != 0 || col_busbad != 0) begin
            tests_failed++;
            $display("FAIL single_frame bus: unstable=%0d busbad=%0d, required 0/0", col_unstable, col_busbad);
        end
        tests_run++;
        if ({ALE, En, Rw, busy} !== 4'b0010 || dispReg !== '0) begin
            tests_failed++;
            $display("FAIL single_frame end: ALE,En,Rw,busy=%b dispReg=%h, required 0010 / 00", {ALE, En, Rw, busy}, dispReg);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests_run++;
            if (obs_q.size() == 0) begin
                tests_failed++;
                $display("FAIL single_frame strobe missing: required kind=%0d val=%h len=%0d", e.kind, e.val, e.len);
            end else begin
                o = obs_q.pop_front();
                if (o.kind !== e.kind || o.val !== e.val || o.len != e.len) begin
                    tests_failed++;
                    $display("FAIL single_frame strobe: got kind=%0d val=%h len=%0d, required kind=%0d val=%h len=%0d",
                             o.kind, o.val, o.len, e.kind, e.val, e.len);
                end
            end
        end
        @(negedge clk);
        tests_run++;
        if (frameDone !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_frame pulse width: frameDone=%b one cycle later, required 0", frameDone);
        end
    endtask

    task automatic test_tear_free();
        obs_t e, o;
        regSelect = 2'd2;
        push_frame(2, 16'hA5C3);
        pause = 1'b0;
        fork
            collect_frame(60);
            begin : mutate
                int   rises;
                logic prev;
                rises = 0; prev = 1'b0;
                for (int c = 0; c < 60 && rises < 2; c++) begin
                    @(negedge clk);
                    if (En && !prev) rises++;
                    prev = En;
                end
                regFile[2*REG_W +: REG_W] = 16'hFFFF;
                regSelect = 2'd1;
            end
        join
        pause = 1'b1;
        for (int f = 0; f < 2; f++) begin
            if (f == 1) begin
                push_frame(1, reg_of(1));
                pause = 1'b0;
                collect_frame(60);
                pause = 1'b1;
            end
            tests_run++;
            if (col_fd != int'(FRAME_LEN)) begin
                tests_failed++;
                $display("FAIL tear_free frame%0d length: got %0d, required %0d", f, col_fd, FRAME_LEN);
            end
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                tests_run++;
                if (obs_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL tear_free frame%0d strobe missing: required kind=%0d val=%h", f, e.kind, e.val);
                end else begin
                    o = obs_q.pop_front();
                    if (o.kind !== e.kind || o.val !== e.val || o.len != e.len) begin
                        tests_failed++;
                        $display("FAIL tear_free frame%0d strobe: got kind=%0d val=%h len=%0d, required kind=%0d val=%h len=%0d",
                                 f, o.kind, o.val, o.len, e.kind, e.val, e.len);
                    end
                end
            end
        end
        regFile[2*REG_W +: REG_W] = 16'hA5C3;
    endtask

    task automatic test_pause_mid_strobe();
        obs_t e, o;
        regSelect = 2'd3;
        push_frame(3, reg_of(3));
        exp_q[1].len = int'(STROBE_CYC) + 5;
        pause = 1'b0;
        fork
            collect_frame(80);
            begin : stim
                logic [BUS_W-1:0] held;
                int               after;
                bit               seen;
                seen = 1'b0;
                for (int c = 0; c < 80 && !seen; c++) begin
                    @(negedge clk);
                    seen = (En === 1'b1);
                end
                @(negedge clk);
                held  = dispReg;
                pause = 1'b1;
                for (int i = 0; i < 5; i++) begin
                    if (i > 0) @(negedge clk);
                    tests_run++;
                    if (En !== 1'b1 || dispReg !== held) begin
                        tests_failed++;
                        $display("FAIL pause_hold cyc%0d: En=%b dispReg=%h, required 1 / %h", i, En, dispReg, held);
                    end
                end
                @(negedge clk);
                pause = 1'b0;
                after = 0;
                for (int i = 0; i < 10 && En === 1'b1; i++) begin
                    after++;
                    @(negedge clk);
                end
                tests_run++;
                if (after != 1) begin
                    tests_failed++;
                    $display("FAIL pause_release: En high %0d cycles after release, required 1", after);
                end
            end
        join
        pause = 1'b1;
        tests_run++;
        if (col_fd != int'(FRAME_LEN) + 5 || col_unstable != 0) begin
            tests_failed++;
            $display("FAIL pause_frame: length %0d unstable %0d, required %0d / 0", col_fd, col_unstable, FRAME_LEN + 5);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests_run++;
            if (obs_q.size() == 0) begin
                tests_failed++;
                $display("FAIL pause_frame strobe missing: required kind=%0d val=%h", e.kind, e.val);
            end else begin
                o = obs_q.pop_front();
                if (o.kind !== e.kind || o.val !== e.val || o.len != e.len) begin
                    tests_failed++;
                    $display("FAIL pause_frame strobe: got kind=%0d val=%h len=%0d, required kind=%0d val=%h len=%0d",
                             o.kind, o.val, o.len, e.kind, e.val, e.len);
                end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        obs_t e, o;
        int   falls;
        logic prev;
        regSelect = 2'd2;
        pause = 1'b0;
        falls = 0; prev = 1'b0;
        for (int c = 0; c < 60 && falls < 2; c++) begin
            @(negedge clk);
            if (!En && prev) falls++;
            prev = En;
        end
        @(negedge clk);
        tests_run++;
        if (En !== 1'b0 || dispReg !== 5'h0E) begin
            tests_failed++;
            $display("FAIL reset_mid setup: En=%b dispReg=%h, required 0 / 0e", En, dispReg);
        end
        rst = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({ALE, En, Rw, busy, frameDone} !== 5'b00100 || dispReg !== '0) begin
            tests_failed++;
            $display("FAIL reset_mid values: ALE,En,Rw,busy,frameDone=%b dispReg=%h, required 00100 / 00",
                     {ALE, En, Rw, busy, frameDone}, dispReg);
        end
        rst = 1'b0;
        push_frame(2, reg_of(2));
        collect_frame(60);
        pause = 1'b1;
        tests_run++;
        if (col_ale0 != 0 || col_fd != int'(FRAME_LEN)) begin
            tests_failed++;
            $display("FAIL reset_mid restart: ALE start %0d length %0d, required 0 / %0d", col_ale0, col_fd, FRAME_LEN);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests_run++;
            if (obs_q.size() == 0) begin
                tests_failed++;
                $display("FAIL reset_mid strobe missing: required kind=%0d val=%h", e.kind, e.val);
            end else begin
                o = obs_q.pop_front();
                if (o.kind !== e.kind || o.val !== e.val || o.len != e.len) begin
                    tests_failed++;
                    $display("FAIL reset_mid strobe: got kind=%0d val=%h len=%0d, required kind=%0d val=%h len=%0d",
                             o.kind, o.val, o.len, e.kind, e.val, e.len);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        obs_t e, o;
        regSelect = 2'd0;
        pause = 1'b0;
        for (int f = 0; f < 2; f++) begin
            push_frame(f == 0 ? 0 : 3, reg_of(f == 0 ? 0 : 3));
            collect_frame(60);
            regSelect = 2'd3;
            tests_run++;
            if (col_fd != int'(FRAME_LEN) || (f == 1 && col_ale0 != 0)) begin
                tests_failed++;
                $display("FAIL back_to_back frame%0d: length %0d ALE start %0d, required %0d / 0", f, col_fd, col_ale0, FRAME_LEN);
            end
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                tests_run++;
                if (obs_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL back_to_back frame%0d strobe missing: required kind=%0d val=%h", f, e.kind, e.val);
                end else begin
                    o = obs_q.pop_front();
                    if (o.kind !== e.kind || o.val !== e.val || o.len != e.len) begin
                        tests_failed++;
                        $display("FAIL back_to_back frame%0d strobe: got kind=%0d val=%h len=%0d, required kind=%0d val=%h len=%0d",
                                 f, o.kind, o.val, o.len, e.kind, e.val, e.len);
                    end
                end
            end
        end
        pause = 1'b1;
    endtask

`ifdef REG_DISP_SCAN_EN
    task automatic test_scan_wrap();
        obs_t e, o;
        scanMode = 1'b1;
        for (int f = 0; f < 5; f++) begin
            regSelect = 2'(3 - (f % 4));
            push_frame(f % 4, reg_of(f % 4));
            pause = 1'b0;
            collect_frame(60);
            pause = 1'b1;
            tests_run++;
            if (col_fd != int'(FRAME_LEN)) begin
                tests_failed++;
                $display("FAIL scan frame%0d length: got %0d, required %0d", f, col_fd, FRAME_LEN);
            end
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                tests_run++;
                if (obs_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL scan frame%0d strobe missing: required kind=%0d val=%h", f, e.kind, e.val);
                end else begin
                    o = obs_q.pop_front();
                    if (o.kind !== e.kind || o.val !== e.val || o.len != e.len) begin
                        tests_failed++;
                        $display("FAIL scan frame%0d strobe: got kind=%0d val=%h len=%0d, required kind=%0d val=%h len=%0d",
                                 f, o.kind, o.val, o.len, e.kind, e.val, e.len);
                    end
                end
            end
        end
        scanMode = 1'b0;
    endtask
`endif

    initial begin
        rst       = 1'b1;
        pause     = 1'b1;
        regSelect = 2'd0;
        regFile   = {16'h0F0F, 16'hA5C3, 16'hBEEF, 16'h1234};
`ifdef REG_DISP_SCAN_EN
        scanMode  = 1'b0;
`endif
        test_reset();
        test_single_frame();
        test_tear_free();
        test_pause_mid_strobe();
        test_reset_mid_frame();
        test_back_to_back();
`ifdef REG_DISP_SCAN_EN
        test_scan_wrap();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
